// File: rtl/alu_seq_core.sv
// Operand-load ALU: A/B loaded from a shared bus, single-cycle logic/arith ops,
// and an optional WIDTH-cycle shift-add multiplier. Result and flags stay registered.
module alu_seq_core #(
  parameter int WIDTH  = 4,
  parameter bit MUL_EN = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   data_in,
  input  logic               ld_a,
  input  logic               ld_b,
  input  logic [2:0]         op,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result,
  output logic               flag_zero,
  output logic               flag_carry,
  output logic               flag_neg
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {IDLE, MUL} state_t;

  typedef struct packed {
    logic [2*WIDTH-1:0] res;
    logic               carry;
  } alu_out_t;

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   a_q, b_q, mplier;
  logic [2*WIDTH-1:0] mcand, acc, acc_nxt;
  logic [CW-1:0]      cnt;
  logic [WIDTH:0]     sum, diff;
  alu_out_t           sc;
  logic               mul_go, last_iter;

  assign mul_go    = MUL_EN && (op == 3'b111);
  assign last_iter = (cnt == CW'(WIDTH - 1));
  assign acc_nxt   = acc + (mplier[0] ? mcand : '0);
  assign sum       = {1'b0, a_q} + {1'b0, b_q};
  assign diff      = {1'b0, a_q} - {1'b0, b_q};
  assign busy      = (state == MUL);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start && mul_go) state_nxt = MUL;
      MUL:     if (last_iter) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Single-cycle ops only ever populate the low half; op 111 without a multiplier lands in default (all zero).
  always_comb begin
    sc = '0;
    case (op)
      3'b000: begin sc.res[WIDTH-1:0] = sum[WIDTH-1:0];  sc.carry = sum[WIDTH];  end
      3'b001: begin sc.res[WIDTH-1:0] = diff[WIDTH-1:0]; sc.carry = diff[WIDTH]; end
      3'b010: sc.res[WIDTH-1:0] = a_q & b_q;
      3'b011: sc.res[WIDTH-1:0] = a_q | b_q;
      3'b100: sc.res[WIDTH-1:0] = a_q ^ b_q;
      3'b101: sc.res[WIDTH-1:0] = (32'(b_q) >= WIDTH) ? '0 : (a_q << b_q);
      3'b110: sc.res[WIDTH-1:0] = (32'(b_q) >= WIDTH) ? '0 : (a_q >> b_q);
      default: sc = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q        <= '0;
      b_q        <= '0;
      mcand      <= '0;
      mplier     <= '0;
      acc        <= '0;
      cnt        <= '0;
      result     <= '0;
      flag_zero  <= 1'b0;
      flag_carry <= 1'b0;
      flag_neg   <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (ld_a) a_q <= data_in;
          if (ld_b) b_q <= data_in;
          // Start samples the pre-load operands; the load above still lands.
          if (start) begin
            if (mul_go) begin
              mcand  <= {{WIDTH{1'b0}}, a_q};
              mplier <= b_q;
              acc    <= '0;
              cnt    <= '0;
            end else begin
              result     <= sc.res;
              flag_carry <= sc.carry;
              flag_zero  <= (sc.res == '0);
              flag_neg   <= sc.res[WIDTH-1];
              done       <= 1'b1;
            end
          end
        end
        MUL: begin
          acc    <= acc_nxt;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          if (last_iter) begin
            result     <= acc_nxt;
            flag_carry <= |acc_nxt[2*WIDTH-1:WIDTH];
            flag_zero  <= (acc_nxt == '0);
            flag_neg   <= acc_nxt[WIDTH-1];
            done       <= 1'b1;
            cnt        <= '0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
